// File: rtl/rv32_dmem_responder.sv
// Data-bus responder for the RV32I core.
// Serves loads and stores from a local word-organised RAM and inserts a
// configurable number of wait states per access. Stores that hit the
// 16-byte timer window become one-cycle mtime/mtimecmp update pulses.
// Accesses that hit neither region complete normally and raise addr_err.
module rv32_dmem_responder #(
  parameter int          MEM_LOG2_WORDS    = 14,
  parameter int          READ_WAIT_STATES  = 1,
  parameter int          WRITE_WAIT_STATES = 0,
  parameter logic [31:0] TIMER_BASE_ADDR   = 32'hAFFFFFE0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        wr_mtime,
  output logic        wr_mtimecmp,
  output logic        wr_mtime_upper,
  output logic [31:0] wr_mtime_val,
  output logic        addr_err
);

  localparam int         WORDS   = 1 << MEM_LOG2_WORDS;
  localparam logic [2:0] RD_WAIT = 3'(READ_WAIT_STATES);
  localparam logic [2:0] WR_WAIT = 3'(WRITE_WAIT_STATES);

  // Wait-state counter
  logic [2:0] cnt_q, cnt_d;

  // Address decode
  logic                      req;
  logic                      accept;
  logic                      in_ram;
  logic                      in_timer;
  logic                      ram_hit;
  logic                      rd_only;
  logic [MEM_LOG2_WORDS-1:0] widx;

  // Storage and registered outputs
  logic [31:0] mem_q [WORDS];
  logic [31:0] readdata_q;
  logic        wr_mtime_q;
  logic        wr_mtimecmp_q;
  logic        wr_mtime_upper_q;
  logic [31:0] wr_mtime_val_q;
  logic        addr_err_q;

  // Byte offset within a word plays no part in a word-organised bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[1:0];

  assign req      = read | write;
  assign rd_only  = read & ~write;
  assign in_ram   = (address[31:MEM_LOG2_WORDS+2] == '0);
  assign in_timer = (address[31:4] == TIMER_BASE_ADDR[31:4]);
  // The timer window wins should a large RAM ever overlap it.
  assign ram_hit  = in_ram & ~in_timer;
  assign widx     = address[MEM_LOG2_WORDS+1:2];

  // Writes take priority when read and write are both asserted.
  assign waitrequest = (write & (cnt_q < WR_WAIT)) |
                       (rd_only & (cnt_q < RD_WAIT));

  // Side effects are suppressed while reset is held, so a request that
  // happens to see waitrequest=0 during reset is not committed.
  assign accept = req & ~waitrequest & ~reset;

  // Count waited cycles; restart on acceptance or when the bus goes idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!req || !waitrequest) begin
      cnt_d = 3'd0;
    end else begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Byte-lane store into RAM at the acceptance edge; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && write && ram_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          mem_q[widx][8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Registered load data, refreshed every cycle a read is presented so it
  // is stable by the time the wait states expire.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_q <= 32'h0;
    end else if (rd_only) begin
      readdata_q <= ram_hit ? mem_q[widx] : 32'h0;
    end
  end

  // Timer update pulses and out-of-range flag, one cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_mtime_q       <= 1'b0;
      wr_mtimecmp_q    <= 1'b0;
      wr_mtime_upper_q <= 1'b0;
      wr_mtime_val_q   <= 32'h0;
      addr_err_q       <= 1'b0;
    end else begin
      wr_mtime_q    <= accept & write & in_timer & ~address[3];
      wr_mtimecmp_q <= accept & write & in_timer &  address[3];
      addr_err_q    <= accept & ~in_ram & ~in_timer;
      if (accept && write && in_timer) begin
        wr_mtime_upper_q <= address[2];
        wr_mtime_val_q   <= writedata;
      end
    end
  end

  assign readdata       = readdata_q;
  assign wr_mtime       = wr_mtime_q;
  assign wr_mtimecmp    = wr_mtimecmp_q;
  assign wr_mtime_upper = wr_mtime_upper_q;
  assign wr_mtime_val   = wr_mtime_val_q;
  assign addr_err       = addr_err_q;

endmodule

// File: tb/tb_rv32_dmem_responder.sv
// Directed bench for rv32_dmem_responder.
// Instance A uses the default wait states (read 1, write 0); instance B
// uses 3 read and 3 write wait states. Both share clock and bus inputs but
// have separate request strobes and resets.
module tb_rv32_dmem_responder;

  localparam logic [31:0] TBASE = 32'hAFFFFFE0;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic [31:0] address;
  logic        read_a, write_a, read_b, write_b;
  logic [31:0] writedata;
  logic [3:0]  byteenable;

  logic [31:0] readdata_a, readdata_b, wr_mtime_val_a, wr_mtime_val_b;
  logic        wait_a, wait_b;
  logic        wr_mtime_a, wr_mtime_b, wr_mtimecmp_a, wr_mtimecmp_b;
  logic        wr_mtime_upper_a, wr_mtime_upper_b, addr_err_a, addr_err_b;

  logic        use_b;
  logic        wreq;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign wreq  = use_b ? wait_b : wait_a;
  assign rdata = use_b ? readdata_b : readdata_a;

  rv32_dmem_responder #(
    .MEM_LOG2_WORDS(10), .READ_WAIT_STATES(1), .WRITE_WAIT_STATES(0),
    .TIMER_BASE_ADDR(TBASE)
  ) dut_a (
    .clk(clk), .reset(rst_a), .address(address), .read(read_a), .write(write_a),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata_a),
    .waitrequest(wait_a), .wr_mtime(wr_mtime_a), .wr_mtimecmp(wr_mtimecmp_a),
    .wr_mtime_upper(wr_mtime_upper_a), .wr_mtime_val(wr_mtime_val_a),
    .addr_err(addr_err_a)
  );

  rv32_dmem_responder #(
    .MEM_LOG2_WORDS(10), .READ_WAIT_STATES(3), .WRITE_WAIT_STATES(3),
    .TIMER_BASE_ADDR(TBASE)
  ) dut_b (
    .clk(clk), .reset(rst_b), .address(address), .read(read_b), .write(write_b),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata_b),
    .waitrequest(wait_b), .wr_mtime(wr_mtime_b), .wr_mtimecmp(wr_mtimecmp_b),
    .wr_mtime_upper(wr_mtime_upper_b), .wr_mtime_val(wr_mtime_val_b),
    .addr_err(addr_err_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Count waited cycles until waitrequest drops; sample at the falling edge.
  task automatic wait_accept(output int waits, output logic [31:0] rd);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = 32'h0;
    while (!done) begin
      @(negedge clk);
      if (!wreq) begin
        rd   = rdata;
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 20) begin
          chk("timeout", 32'(waits), 32'd0);
          done = 1'b1;
        end
      end
    end
  endtask

  // Present one request, wait for acceptance, then drop it one time unit
  // after the accepting edge.
  task automatic do_access(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, output int waits, output logic [31:0] rd);
    address    = a;
    writedata  = d;
    byteenable = be;
    if (use_b) begin
      read_b = ~is_wr; write_b = is_wr;
    end else begin
      read_a = ~is_wr; write_a = is_wr;
    end
    wait_accept(waits, rd);
    @(posedge clk); #1;
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
  endtask

  int          w;
  logic [31:0] r;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; use_b = 1'b0;
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    address = 32'h0; writedata = 32'h0; byteenable = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("rst_readdata", readdata_a, 32'h0);
    chk("rst_wait", {31'b0, wait_a}, 32'h0);
    chk("rst_pulses", {28'b0, wr_mtime_a, wr_mtimecmp_a, wr_mtime_upper_a, addr_err_a}, 32'h0);
    chk("rst_val", wr_mtime_val_a, 32'h0);

    // Full-word write with no wait states, then read back with one
    do_access(1'b1, 32'h100, 32'h12345678, 4'hF, w, r);
    chk("wr0_waits", 32'(w), 32'd0);
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    chk("rd1_waits", 32'(w), 32'd1);
    chk("rd1_data", r, 32'h12345678);

    // Byte-lane merge and empty byteenable
    do_access(1'b1, 32'h100, 32'hAABBCCDD, 4'b0101, w, r);
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    chk("be0101_data", r, 32'h12BB56DD);
    do_access(1'b1, 32'h100, 32'hFFFFFFFF, 4'h0, w, r);
    chk("be0_waits", 32'(w), 32'd0);
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    chk("be0_data", r, 32'h12BB56DD);

    // Timer window: mtimecmp high, then mtime low
    do_access(1'b1, TBASE + 32'hC, 32'h000003E8, 4'h1, w, r);
    chk("cmp_pulse", {31'b0, wr_mtimecmp_a}, 32'h1);
    chk("cmp_mtime", {31'b0, wr_mtime_a}, 32'h0);
    chk("cmp_upper", {31'b0, wr_mtime_upper_a}, 32'h1);
    chk("cmp_val", wr_mtime_val_a, 32'h000003E8);
    @(posedge clk); #1;
    chk("cmp_once", {31'b0, wr_mtimecmp_a}, 32'h0);
    do_access(1'b1, TBASE, 32'h5A5A0001, 4'hF, w, r);
    chk("mt_pulse", {30'b0, wr_mtime_a, wr_mtimecmp_a}, 32'h2);
    chk("mt_upper", {31'b0, wr_mtime_upper_a}, 32'h0);
    chk("mt_val", wr_mtime_val_a, 32'h5A5A0001);
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    do_access(1'b0, TBASE, 32'h0, 4'h0, w, r);
    chk("trd_waits", 32'(w), 32'd1);
    chk("trd_data", r, 32'h0);

    // Out of range: read returns zero, addr_err pulses once, write dropped
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    do_access(1'b0, 32'h80000000, 32'h0, 4'h0, w, r);
    chk("oor_rd_data", r, 32'h0);
    chk("oor_err", {31'b0, addr_err_a}, 32'h1);
    @(posedge clk); #1;
    chk("oor_err_once", {31'b0, addr_err_a}, 32'h0);
    do_access(1'b1, 32'h80000100, 32'h00000000, 4'hF, w, r);
    chk("oor_wr_err", {31'b0, addr_err_a}, 32'h1);
    chk("oor_wr_nopulse", {30'b0, wr_mtime_a, wr_mtimecmp_a}, 32'h0);
    do_access(1'b0, 32'h100, 32'h0, 4'h0, w, r);
    chk("oor_ram_kept", r, 32'h12BB56DD);
    chk("inrange_noerr", {31'b0, addr_err_a}, 32'h0);

    // Instance B: three wait states, back-to-back reads
    use_b = 1'b1;
    do_access(1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, w, r);
    chk("b_wr_waits", 32'(w), 32'd3);
    do_access(1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, w, r);
    do_access(1'b0, 32'h0, 32'h0, 4'h0, w, r);
    chk("b_rd0_waits", 32'(w), 32'd3);
    chk("b_rd0_data", r, 32'hA0A0A0A0);
    do_access(1'b0, 32'h4, 32'h0, 4'h0, w, r);
    chk("b_rd1_waits", 32'(w), 32'd3);
    chk("b_rd1_data", r, 32'hB1B1B1B1);

    // Reset during the second wait cycle of a write
    address = 32'h200; writedata = 32'hCAFEF00D; byteenable = 4'hF;
    write_b = 1'b1;
    @(posedge clk); #1;
    chk("b_mid_wait", {31'b0, wait_b}, 32'h1);
    rst_b = 1'b1;
    @(posedge clk); #1;
    chk("b_rst_readdata", readdata_b, 32'h0);
    chk("b_rst_wait", {31'b0, wait_b}, 32'h1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    wait_accept(w, r);
    chk("b_rst_rewaits", 32'(w), 32'd3);
    @(posedge clk); #1;
    write_b = 1'b0;
    do_access(1'b0, 32'h200, 32'h0, 4'h0, w, r);
    chk("b_rst_commit", r, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
